// File: rtl/baseaddr_loop_pn_if.sv
// Bundle between the frame-buffer pointer arbiter, the write DMA and the read channels.
// The master side drives vsync/enable/reader pointers; the arbiter is the slave.
interface baseaddr_loop_pn_if #(
    parameter int unsigned NBUF = 5,
    parameter int unsigned NRD  = 3
);
    logic                 enable;
    logic                 wr_vs;
    logic [NRD*NBUF-1:0]  rd_curr_point;
    logic [NBUF-1:0]      wr_current_point;
    logic [NBUF-1:0]      last_done_point;
    logic                 last_valid;
    logic                 frame_drop;
    logic [15:0]          frame_cnt;
    logic [15:0]          drop_cnt;

    modport master (
        output enable, wr_vs, rd_curr_point,
        input  wr_current_point, last_done_point, last_valid, frame_drop, frame_cnt, drop_cnt
    );

    modport slave (
        input  enable, wr_vs, rd_curr_point,
        output wr_current_point, last_done_point, last_valid, frame_drop, frame_cnt, drop_cnt
    );
endinterface

// File: rtl/baseaddr_loop_pn.sv
// Frame-buffer pointer arbiter: on each write-vsync edge, moves the writer to a buffer that
// neither it nor any reader holds, and publishes the last completed frame to the readers.
module baseaddr_loop_pn #(
    parameter int unsigned NBUF = 5,
    parameter int unsigned NRD  = 3,
    parameter int unsigned RR   = 1
) (
    input logic               wclk,
    input logic               wrst_n,
    baseaddr_loop_pn_if.slave bus_io
);
    localparam int unsigned IW = (NBUF > 1) ? $clog2(NBUF) : 1;
    localparam logic [NBUF-1:0] CurRst = NBUF'(1);

    logic            vs_q1, vs_q2, rise;
    logic [NBUF-1:0] free_q, rd_busy, sel;
    logic [NBUF-1:0] cur_q, cur_d, last_q, last_d;
    logic [IW-1:0]   cur_idx, scan_idx;
    logic            valid_q, valid_d, started_q, started_d;
    logic            accept, refuse;
    logic [15:0]     frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

    assign rise   = vs_q1 & ~vs_q2;
    assign accept = rise & (|sel);
    assign refuse = rise & ~(|sel);

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            rd_busy |= bus_io.rd_curr_point[i*NBUF +: NBUF];
        end
    end

    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < NBUF; i++) begin
            if (cur_q[i]) cur_idx = IW'(i);
        end
    end

    // Rotating search begins just past the current buffer so buffers are reused evenly.
    always_comb begin
        sel      = '0;
        scan_idx = '0;
        if (RR != 0) begin
            for (int unsigned s = 1; s <= NBUF; s++) begin
                scan_idx = IW'((32'(cur_idx) + s) % NBUF);
                if (sel == '0 && free_q[scan_idx]) sel[scan_idx] = 1'b1;
            end
        end else begin
            for (int i = 0; i < NBUF; i++) begin
                if (sel == '0 && free_q[i]) sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        cur_d       = cur_q;
        last_d      = last_q;
        valid_d     = valid_q;
        started_d   = started_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (accept) begin
            cur_d       = sel;
            last_d      = cur_q;
            // The frame in progress at reset is partial, so it never counts as complete.
            valid_d     = started_q;
            started_d   = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (refuse && drop_cnt_q != 16'hffff) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            vs_q1       <= 1'b0;
            vs_q2       <= 1'b0;
            free_q      <= '0;
            cur_q       <= CurRst;
            last_q      <= '0;
            valid_q     <= 1'b0;
            started_q   <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            vs_q1       <= bus_io.wr_vs & bus_io.enable;
            vs_q2       <= vs_q1;
            free_q      <= ~(cur_q | rd_busy);
            cur_q       <= cur_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
            started_q   <= started_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign bus_io.wr_current_point = cur_q;
    assign bus_io.last_done_point  = last_q;
    assign bus_io.last_valid       = valid_q;
    assign bus_io.frame_drop       = refuse;
    assign bus_io.frame_cnt        = frame_cnt_q;
    assign bus_io.drop_cnt         = drop_cnt_q;
endmodule

// File: tb/tb_baseaddr_loop_pn.sv
// Bench for baseaddr_loop_pn: a rotating-search instance and a lowest-first instance share
// one stimulus; expected snapshots are queued per instance and compared after each vsync pulse.
module tb_baseaddr_loop_pn;
    localparam int unsigned NBUF = 5;
    localparam int unsigned NRD  = 3;

    typedef struct packed {
        logic [4:0]  cur;
        logic [4:0]  last;
        logic        valid;
        logic        drop_mid;
        logic        drop_post;
        logic [15:0] fcnt;
        logic [15:0] dcnt;
    } obs_t;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b0;
    always #5 wclk = ~wclk;

    baseaddr_loop_pn_if #(.NBUF(NBUF), .NRD(NRD)) if_a ();
    baseaddr_loop_pn_if #(.NBUF(NBUF), .NRD(NRD)) if_b ();

    assign if_b.enable        = if_a.enable;
    assign if_b.wr_vs         = if_a.wr_vs;
    assign if_b.rd_curr_point = if_a.rd_curr_point;

    baseaddr_loop_pn #(.NBUF(NBUF), .NRD(NRD), .RR(1)) dut_a (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus_io (if_a)
    );

    baseaddr_loop_pn #(.NBUF(NBUF), .NRD(NRD), .RR(0)) dut_b (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus_io (if_b)
    );

    obs_t q_a[$];
    obs_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    function automatic obs_t mk(input logic [4:0] cur, input logic [4:0] last, input logic valid,
                                input logic drop, input logic [15:0] fcnt,
                                input logic [15:0] dcnt);
        return '{cur, last, valid, drop, 1'b0, fcnt, dcnt};
    endfunction

    function automatic obs_t snap_a(input logic dm, input logic dp);
        return '{if_a.wr_current_point, if_a.last_done_point, if_a.last_valid, dm, dp,
                 if_a.frame_cnt, if_a.drop_cnt};
    endfunction

    function automatic obs_t snap_b(input logic dm, input logic dp);
        return '{if_b.wr_current_point, if_b.last_done_point, if_b.last_valid, dm, dp,
                 if_b.frame_cnt, if_b.drop_cnt};
    endfunction

    // One-cycle vsync pulse; frame_drop is sampled while rise is high and again one cycle later.
    task automatic pulse(output obs_t oa, output obs_t ob);
        logic dma, dmb;
        @(negedge wclk);
        if_a.wr_vs = 1'b1;
        @(negedge wclk);
        if_a.wr_vs = 1'b0;
        dma = if_a.frame_drop;
        dmb = if_b.frame_drop;
        @(negedge wclk);
        oa = snap_a(dma, if_a.frame_drop);
        ob = snap_b(dmb, if_b.frame_drop);
    endtask

    task automatic reset_dut();
        wrst_n             = 1'b0;
        if_a.wr_vs         = 1'b0;
        if_a.enable        = 1'b1;
        if_a.rd_curr_point = '0;
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;
        @(negedge wclk);
    endtask

    task automatic test_reset();
        obs_t oa, ob, e;
        reset_dut();
        q_a.push_back(mk(5'b00001, 5'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        q_b.push_back(mk(5'b00001, 5'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        oa = snap_a(if_a.frame_drop, if_a.frame_drop);
        ob = snap_b(if_b.frame_drop, if_b.frame_drop);
        e = q_a.pop_front(); checks++;
        if (oa !== e) begin errors++; $display("FAIL reset_rr: got %h want %h", oa, e); end
        e = q_b.pop_front(); checks++;
        if (ob !== e) begin errors++; $display("FAIL reset_low: got %h want %h", ob, e); end
    endtask

    task automatic test_basic();
        obs_t oa, ob, e;
        logic [4:0] cur, last;
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            cur  = 5'b00001 << (k + 1);
            last = 5'b00001 << k;
            q_a.push_back(mk(cur, last, k > 0, 1'b0, 16'(k + 1), 16'd0));
            pulse(oa, ob);
            e = q_a.pop_front(); checks++;
            if (oa !== e) begin errors++; $display("FAIL basic_%0d: got %h want %h", k, oa, e); end
        end
    endtask

    task automatic test_rr_vs_lowest();
        obs_t oa, ob, e;
        reset_dut();
        if_a.rd_curr_point = {5'b00000, 5'b00000, 5'b00010};
        @(negedge wclk);
        q_a.push_back(mk(5'b00100, 5'b00001, 1'b0, 1'b0, 16'd1, 16'd0));
        q_b.push_back(mk(5'b00100, 5'b00001, 1'b0, 1'b0, 16'd1, 16'd0));
        pulse(oa, ob);
        e = q_a.pop_front(); checks++;
        if (oa !== e) begin errors++; $display("FAIL rr_first: got %h want %h", oa, e); end
        e = q_b.pop_front(); checks++;
        if (ob !== e) begin errors++; $display("FAIL low_first: got %h want %h", ob, e); end
        q_a.push_back(mk(5'b01000, 5'b00100, 1'b1, 1'b0, 16'd2, 16'd0));
        q_b.push_back(mk(5'b00001, 5'b00100, 1'b1, 1'b0, 16'd2, 16'd0));
        pulse(oa, ob);
        e = q_a.pop_front(); checks++;
        if (oa !== e) begin errors++; $display("FAIL rr_second: got %h want %h", oa, e); end
        e = q_b.pop_front(); checks++;
        if (ob !== e) begin errors++; $display("FAIL low_second: got %h want %h", ob, e); end
    endtask

    task automatic test_all_busy();
        obs_t oa, ob, e;
        reset_dut();
        if_a.rd_curr_point = {5'b11000, 5'b00100, 5'b00010};
        @(negedge wclk);
        q_a.push_back(mk(5'b00001, 5'b0, 1'b0, 1'b1, 16'd0, 16'd1));
        q_b.push_back(mk(5'b00001, 5'b0, 1'b0, 1'b1, 16'd0, 16'd1));
        pulse(oa, ob);
        e = q_a.pop_front(); checks++;
        if (oa !== e) begin errors++; $display("FAIL busy_drop_rr: got %h want %h", oa, e); end
        e = q_b.pop_front(); checks++;
        if (ob !== e) begin errors++; $display("FAIL busy_drop_low: got %h want %h", ob, e); end
        if_a.rd_curr_point = {5'b00000, 5'b00100, 5'b00010};
        q_a.push_back(mk(5'b01000, 5'b00001, 1'b0, 1'b0, 16'd1, 16'd1));
        q_b.push_back(mk(5'b01000, 5'b00001, 1'b0, 1'b0, 16'd1, 16'd1));
        pulse(oa, ob);
        e = q_a.pop_front(); checks++;
        if (oa !== e) begin errors++; $display("FAIL busy_release_rr: got %h want %h", oa, e); end
        e = q_b.pop_front(); checks++;
        if (ob !== e) begin errors++; $display("FAIL busy_release_low: got %h want %h", ob, e); end
    endtask

    task automatic test_enable();
        obs_t oa, ob, e;
        reset_dut();
        if_a.enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            q_a.push_back(mk(5'b00001, 5'b0, 1'b0, 1'b0, 16'd0, 16'd0));
            pulse(oa, ob);
            e = q_a.pop_front(); checks++;
            if (oa !== e) begin errors++; $display("FAIL gated_%0d: got %h want %h", k, oa, e); end
        end
        @(negedge wclk);
        if_a.wr_vs = 1'b1;
        @(negedge wclk);
        if_a.enable = 1'b1;
        @(negedge wclk);
        q_a.push_back(mk(5'b00001, 5'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        oa = snap_a(if_a.frame_drop, if_a.frame_drop);
        e = q_a.pop_front(); checks++;
        if (oa !== e) begin errors++; $display("FAIL en_before: got %h want %h", oa, e); end
        @(negedge wclk);
        q_a.push_back(mk(5'b00010, 5'b00001, 1'b0, 1'b0, 16'd1, 16'd0));
        oa = snap_a(if_a.frame_drop, if_a.frame_drop);
        e = q_a.pop_front(); checks++;
        if (oa !== e) begin errors++; $display("FAIL en_switch: got %h want %h", oa, e); end
        repeat (5) @(negedge wclk);
        q_a.push_back(mk(5'b00010, 5'b00001, 1'b0, 1'b0, 16'd1, 16'd0));
        oa = snap_a(if_a.frame_drop, if_a.frame_drop);
        e = q_a.pop_front(); checks++;
        if (oa !== e) begin errors++; $display("FAIL en_held: got %h want %h", oa, e); end
        if_a.wr_vs = 1'b0;
        @(negedge wclk);
    endtask

    task automatic test_counters();
        obs_t oa, ob, e;
        logic [15:0] dexp;
        reset_dut();
        if_a.rd_curr_point = {5'b11000, 5'b00100, 5'b00010};
        @(negedge wclk);
        force dut_a.drop_cnt_q = 16'hfffd;
        @(negedge wclk);
        release dut_a.drop_cnt_q;
        for (int k = 0; k < 3; k++) begin
            dexp = (k == 0) ? 16'hfffe : 16'hffff;
            q_a.push_back(mk(5'b00001, 5'b0, 1'b0, 1'b1, 16'd0, dexp));
            pulse(oa, ob);
            e = q_a.pop_front(); checks++;
            if (oa !== e) begin errors++; $display("FAIL drop_sat_%0d: got %h want %h", k, oa, e); end
        end
        reset_dut();
        force dut_a.frame_cnt_q = 16'hfffe;
        @(negedge wclk);
        release dut_a.frame_cnt_q;
        q_a.push_back(mk(5'b00010, 5'b00001, 1'b0, 1'b0, 16'hffff, 16'd0));
        q_a.push_back(mk(5'b00100, 5'b00010, 1'b1, 1'b0, 16'h0000, 16'd0));
        for (int k = 0; k < 2; k++) begin
            pulse(oa, ob);
            e = q_a.pop_front(); checks++;
            if (oa !== e) begin errors++; $display("FAIL fcnt_wrap_%0d: got %h want %h", k, oa, e); end
        end
    endtask

    task automatic test_reset_mid();
        obs_t oa, ob, e;
        reset_dut();
        q_a.push_back(mk(5'b00010, 5'b00001, 1'b0, 1'b0, 16'd1, 16'd0));
        q_a.push_back(mk(5'b00100, 5'b00010, 1'b1, 1'b0, 16'd2, 16'd0));
        for (int k = 0; k < 2; k++) begin
            pulse(oa, ob);
            e = q_a.pop_front(); checks++;
            if (oa !== e) begin errors++; $display("FAIL pre_rst_%0d: got %h want %h", k, oa, e); end
        end
        @(negedge wclk);
        if_a.wr_vs = 1'b1;
        @(posedge wclk);
        #2 wrst_n = 1'b0;
        #1;
        q_a.push_back(mk(5'b00001, 5'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        oa = snap_a(if_a.frame_drop, if_a.frame_drop);
        e = q_a.pop_front(); checks++;
        if (oa !== e) begin errors++; $display("FAIL rst_async: got %h want %h", oa, e); end
        @(negedge wclk);
        if_a.wr_vs = 1'b0;
        @(negedge wclk);
        wrst_n = 1'b1;
        repeat (2) @(negedge wclk);
        q_a.push_back(mk(5'b00001, 5'b0, 1'b0, 1'b0, 16'd0, 16'd0));
        oa = snap_a(if_a.frame_drop, if_a.frame_drop);
        e = q_a.pop_front(); checks++;
        if (oa !== e) begin errors++; $display("FAIL rst_no_switch: got %h want %h", oa, e); end
        q_a.push_back(mk(5'b00010, 5'b00001, 1'b0, 1'b0, 16'd1, 16'd0));
        pulse(oa, ob);
        e = q_a.pop_front(); checks++;
        if (oa !== e) begin errors++; $display("FAIL rst_first_pulse: got %h want %h", oa, e); end
    endtask

    initial begin
        if_a.enable        = 1'b0;
        if_a.wr_vs         = 1'b0;
        if_a.rd_curr_point = '0;
        test_reset();
        test_basic();
        test_rr_vs_lowest();
        test_all_busy();
        test_enable();
        test_counters();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
